// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bus bundle with master (mst_port) and slave (slv_port) views.
// Channels: AW(addr,prot), W(data,strb), B(resp), AR(addr,prot), R(data,resp), each with valid/ready.
interface axi4_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   modport mst_port (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slv_port (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4_lite_mst_arbiter.sv
// axi4_lite_mst_arbiter: round-robin share of one AXI4-Lite master port among NUM_REQ requesters.
// Ports: i_clk, i_async_rst (async, active-high); per-requester i_req_valid/o_req_ready with
// is_wr/addr/wdata/wstrb command payload; o_rsp_valid one-hot pulse with shared o_rsp_rdata/o_rsp_resp;
// o_busy while not IDLE; if_m_axi4_lite AXI4-Lite master port.
module axi4_lite_mst_arbiter #(
   parameter int NUM_REQ                  = 4,
   parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
   parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
   input  logic                                              i_clk,
   input  logic                                              i_async_rst,
   input  logic [NUM_REQ-1:0]                                i_req_valid,
   output logic [NUM_REQ-1:0]                                o_req_ready,
   input  logic [NUM_REQ-1:0]                                i_req_is_wr,
   input  logic [NUM_REQ-1:0][AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_req_addr,
   input  logic [NUM_REQ-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_req_wdata,
   input  logic [NUM_REQ-1:0][AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_req_wstrb,
   output logic [NUM_REQ-1:0]                                o_rsp_valid,
   output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]               o_rsp_rdata,
   output logic [1:0]                                        o_rsp_resp,
   output logic                                              o_busy,
   axi4_lite_if.mst_port                                     if_m_axi4_lite
);
   localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
   localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
   localparam int SW = DW / 8;
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, gnt_q, gnt, gi;
   logic            found, take;
   int              idx;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q, rdata_q;
   logic [SW-1:0]   wstrb_q;
   logic [1:0]      resp_q;
   logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   // first valid requester at or after the pointer, wrapping modulo NUM_REQ
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = 0;
      gi    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         gi = IW'(idx);
         if (!found && i_req_valid[gi]) begin
            found = 1'b1;
            gnt   = gi;
         end
      end
   end
   assign take = (state_q == IDLE) && found;
   // AW and W retire independently; each valid only ever falls inside a write
   assign awvalid_d = take ? i_req_is_wr[gnt]  : awvalid_q & ~if_m_axi4_lite.awready;
   assign wvalid_d  = take ? i_req_is_wr[gnt]  : wvalid_q  & ~if_m_axi4_lite.wready;
   assign arvalid_d = take ? ~i_req_is_wr[gnt] : arvalid_q & ~if_m_axi4_lite.arready;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = found ? (i_req_is_wr[gnt] ? WR : RD_ADDR) : IDLE;
         WR:      state_d = (!awvalid_d && !wvalid_d) ? WR_RESP : WR;
         WR_RESP: state_d = if_m_axi4_lite.bvalid ? RESP : WR_RESP;
         RD_ADDR: state_d = if_m_axi4_lite.arready ? RD_DATA : RD_ADDR;
         RD_DATA: state_d = if_m_axi4_lite.rvalid ? RESP : RD_DATA;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_async_rst) begin
      if (i_async_rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         if (take) begin
            gnt_q    <= gnt;
            addr_q   <= i_req_addr[gnt];
            wdata_q  <= i_req_wdata[gnt];
            wstrb_q  <= i_req_wstrb[gnt];
            rr_ptr_q <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
         end
         if (state_q == WR_RESP && if_m_axi4_lite.bvalid) begin
            resp_q  <= if_m_axi4_lite.bresp;
            rdata_q <= '0;
         end
         if (state_q == RD_DATA && if_m_axi4_lite.rvalid) begin
            resp_q  <= if_m_axi4_lite.rresp;
            rdata_q <= if_m_axi4_lite.rdata;
         end
      end
   end
   // ready is masked during reset so nothing looks accepted while the FSM is held
   assign o_req_ready = (take && !i_async_rst) ? NUM_REQ'(1) << gnt : '0;
   assign o_rsp_valid = (state_q == RESP) ? NUM_REQ'(1) << gnt_q : '0;
   assign o_rsp_rdata = (state_q == RESP) ? rdata_q : '0;
   assign o_rsp_resp  = (state_q == RESP) ? resp_q : '0;
   assign o_busy      = state_q != IDLE;
   assign if_m_axi4_lite.awvalid = awvalid_q;
   assign if_m_axi4_lite.awaddr  = addr_q;
   assign if_m_axi4_lite.awprot  = 3'b000;
   assign if_m_axi4_lite.wvalid  = wvalid_q;
   assign if_m_axi4_lite.wdata   = wdata_q;
   assign if_m_axi4_lite.wstrb   = wstrb_q;
   assign if_m_axi4_lite.bready  = state_q == WR_RESP;
   assign if_m_axi4_lite.arvalid = arvalid_q;
   assign if_m_axi4_lite.araddr  = addr_q;
   assign if_m_axi4_lite.arprot  = 3'b000;
   assign if_m_axi4_lite.rready  = state_q == RD_DATA;
endmodule

// File: tb/tb_axi4_lite_mst_arbiter.sv
// tb_axi4_lite_mst_arbiter: directed checks of the arbiter against a small AXI4-Lite register slave.
module tb_axi4_lite_mst_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [3:0]       req_valid, req_ready, req_is_wr, rsp_valid;
   logic [3:0][31:0] req_addr, req_wdata;
   logic [3:0][3:0]  req_wstrb;
   logic [31:0]      rsp_rdata;
   logic [1:0]       rsp_resp;
   logic             busy;
   axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();
   axi4_lite_mst_arbiter #(
      .NUM_REQ(4), .AXI4_LITE_ADDR_BIT_WIDTH(32), .AXI4_LITE_DATA_BIT_WIDTH(32)
   ) dut (
      .i_clk(clk), .i_async_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_is_wr(req_is_wr),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
      .o_busy(busy), .if_m_axi4_lite(axi)
   );
   // slave: 16 word registers, AWREADY after aw_delay cycles, RVALID r_delay cycles after AR
   int aw_delay = 1;
   int r_delay = 0;
   int aw_cnt, r_cnt;
   logic aw_got, w_got, r_pend;
   logic [31:0] sa, sd, wa, wd;
   logic [3:0] ss, ws;
   logic [31:0] mem [16] = '{default: '0};
   logic aw_hs, w_hs, b_hs, ar_hs;
   assign aw_hs = axi.awvalid & axi.awready;
   assign w_hs  = axi.wvalid & axi.wready;
   assign b_hs  = axi.bvalid & axi.bready;
   assign ar_hs = axi.arvalid & axi.arready;
   assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
   assign axi.wready  = axi.wvalid;
   assign axi.arready = axi.arvalid;
   assign wa = aw_hs ? axi.awaddr : sa;
   assign wd = w_hs ? axi.wdata : sd;
   assign ws = w_hs ? axi.wstrb : ss;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_cnt <= 0; aw_got <= 0; w_got <= 0; r_pend <= 0; r_cnt <= 0;
         axi.bvalid <= 0; axi.bresp <= 0; axi.rvalid <= 0; axi.rdata <= 0; axi.rresp <= 0;
      end else begin
         aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
         if (aw_hs) begin aw_got <= 1; sa <= axi.awaddr; end
         if (w_hs) begin w_got <= 1; sd <= axi.wdata; ss <= axi.wstrb; end
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            for (int b = 0; b < 4; b++) if (ws[b]) mem[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
            axi.bvalid <= 1; axi.bresp <= 2'b00; aw_got <= 0; w_got <= 0;
         end else if (b_hs) axi.bvalid <= 0;
         if (ar_hs) begin
            r_pend <= 1; r_cnt <= 0;
            axi.rdata <= mem[axi.araddr[5:2]];
            axi.rresp <= (axi.araddr == 32'h10) ? 2'b10 : 2'b00;
         end else if (r_pend) begin
            if (r_cnt >= r_delay) begin axi.rvalid <= 1; r_pend <= 0; end
            else r_cnt <= r_cnt + 1;
         end
         if (axi.rvalid && axi.rready) axi.rvalid <= 0;
      end
   end
   // bus monitor: handshake counts and VALID/payload stability
   int aw_rise, w_rise, aw_hs_n, w_hs_n, b_hs_n, w_low_at_aw, viol;
   logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awa, p_wd, p_ara;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         p_awv <= 0; p_wv <= 0; p_arv <= 0; p_awr <= 0; p_wr <= 0; p_arr <= 0;
      end else begin
         if (axi.awvalid && !p_awv) aw_rise <= aw_rise + 1;
         if (axi.wvalid && !p_wv) w_rise <= w_rise + 1;
         if (aw_hs) aw_hs_n <= aw_hs_n + 1;
         if (w_hs) w_hs_n <= w_hs_n + 1;
         if (b_hs) b_hs_n <= b_hs_n + 1;
         if (aw_hs && !axi.wvalid) w_low_at_aw <= w_low_at_aw + 1;
         if ((p_awv && !p_awr && (!axi.awvalid || axi.awaddr != p_awa)) ||
             (p_wv && !p_wr && (!axi.wvalid || axi.wdata != p_wd)) ||
             (p_arv && !p_arr && (!axi.arvalid || axi.araddr != p_ara)) ||
             (axi.arvalid && (axi.awvalid || axi.wvalid)))
            viol <= viol + 1;
         p_awv <= axi.awvalid; p_awr <= axi.awready; p_awa <= axi.awaddr;
         p_wv <= axi.wvalid; p_wr <= axi.wready; p_wd <= axi.wdata;
         p_arv <= axi.arvalid; p_arr <= axi.arready; p_ara <= axi.araddr;
      end
   end
   function automatic int oh_idx(input logic [3:0] v);
      int r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction
   // response recorder
   int n_pulse;
   int pulses [4];
   int rec_idx [64];
   logic [31:0] rec_data [64];
   logic [1:0] rec_resp [64];
   always @(negedge clk) begin
      if (!rst && |rsp_valid) begin
         rec_idx[n_pulse]  <= oh_idx(rsp_valid);
         rec_data[n_pulse] <= rsp_rdata;
         rec_resp[n_pulse] <= rsp_resp;
         pulses[oh_idx(rsp_valid)] <= pulses[oh_idx(rsp_valid)] + 1;
         n_pulse <= n_pulse + 1;
      end
      if ($countones(rsp_valid) > 1 || $countones(req_ready) > 1) viol <= viol + 1;
   end
   int n_chk = 0;
   int n_fail = 0;
   int rd_ptr = 0;
   int gl [32];
   int gn = 0;
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic set_req(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      req_valid[r] = 1'b1; req_is_wr[r] = wr; req_addr[r] = a; req_wdata[r] = d; req_wstrb[r] = s;
   endtask
   task automatic grant(input int n);
      int got = 0;
      int g;
      for (int c = 0; c < 300 && got < n; c++) begin
         #1;
         g = oh_idx(req_ready);
         if (g >= 0) begin
            gl[gn] = g; gn++; got++;
            @(posedge clk); #1;
            req_valid[g] = 1'b0;
         end
         @(negedge clk);
      end
      chk("grant_count", got, n);
   endtask
   task automatic wait_rsp(input int n);
      for (int c = 0; c < 300 && n_pulse - rd_ptr < n; c++) begin
         @(negedge clk); #1;
      end
      chk("rsp_count", n_pulse - rd_ptr, n);
   endtask
   task automatic pop_rsp(input string tag, input int idx, input logic [31:0] d, input logic [1:0] rs);
      chk({tag, "_idx"}, rec_idx[rd_ptr], idx);
      chk({tag, "_data"}, rec_data[rd_ptr], d);
      chk({tag, "_resp"}, rec_resp[rd_ptr], rs);
      rd_ptr++;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   int b_aw, b_w, b_awh, b_wh, b_b, b_wl, b_p;
   initial begin
      req_valid = '0; req_is_wr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {req_ready, rsp_valid, busy, rsp_rdata, rsp_resp, axi.awvalid, axi.wvalid,
                         axi.arvalid, axi.bready, axi.rready}, 64'h0);
      rst = 1'b0;
      // single write then read from requester 0
      set_req(0, 1, 32'h4, 32'hDEADBEEF, 4'hF);
      grant(1);
      chk("t1_wr_gnt", gl[gn-1], 0);
      wait_rsp(1);
      pop_rsp("t1_wr", 0, 32'h0, 2'b00);
      set_req(0, 0, 32'h4, 32'h0, 4'h0);
      grant(1);
      wait_rsp(1);
      pop_rsp("t1_rd", 0, 32'hDEADBEEF, 2'b00);
      chk("t1_p0_pulses", pulses[0], 2);
      chk("t1_other_pulses", pulses[1] + pulses[2] + pulses[3], 0);
      // error response to requester 3, leaves pointer at 0
      set_req(3, 0, 32'h10, 32'h0, 4'h0);
      grant(1);
      chk("err_gnt", gl[gn-1], 3);
      wait_rsp(1);
      pop_rsp("err", 3, 32'h0, 2'b10);
      // round robin with all four requesting
      for (int r = 0; r < 4; r++) set_req(r, 0, 32'(4 * r), 32'h0, 4'h0);
      grant(4);
      for (int r = 0; r < 4; r++) chk($sformatf("rr_gnt%0d", r), gl[gn-4+r], r);
      wait_rsp(4);
      pop_rsp("rr0", 0, 32'h0, 2'b00);
      pop_rsp("rr1", 1, 32'hDEADBEEF, 2'b00);
      pop_rsp("rr2", 2, 32'h0, 2'b00);
      pop_rsp("rr3", 3, 32'h0, 2'b00);
      set_req(0, 0, 32'h0, 32'h0, 4'h0);
      set_req(2, 0, 32'h8, 32'h0, 4'h0);
      grant(2);
      chk("rr2_first", gl[gn-2], 0);
      chk("rr2_second", gl[gn-1], 2);
      wait_rsp(2);
      pop_rsp("rr2a", 0, 32'h0, 2'b00);
      pop_rsp("rr2b", 2, 32'h0, 2'b00);
      // AW stalled three cycles, W accepted at once
      aw_delay = 3;
      b_aw = aw_rise; b_w = w_rise; b_awh = aw_hs_n; b_wh = w_hs_n; b_b = b_hs_n; b_wl = w_low_at_aw;
      set_req(1, 1, 32'h8, 32'h12345678, 4'hF);
      grant(1);
      chk("aww_gnt", gl[gn-1], 1);
      wait_rsp(1);
      pop_rsp("aww", 1, 32'h0, 2'b00);
      chk("aww_aw_rise", aw_rise - b_aw, 1);
      chk("aww_w_rise", w_rise - b_w, 1);
      chk("aww_aw_hs", aw_hs_n - b_awh, 1);
      chk("aww_w_hs", w_hs_n - b_wh, 1);
      chk("aww_b_hs", b_hs_n - b_b, 1);
      chk("aww_w_low_at_aw", w_low_at_aw - b_wl, 1);
      aw_delay = 1;
      // partial strobe into a zeroed register
      set_req(2, 1, 32'hC, 32'hAABBCCDD, 4'h5);
      grant(1);
      wait_rsp(1);
      pop_rsp("strb_wr", 2, 32'h0, 2'b00);
      set_req(2, 0, 32'hC, 32'h0, 4'h0);
      grant(1);
      wait_rsp(1);
      pop_rsp("strb_rd", 2, 32'h00BB00DD, 2'b00);
      // reset while waiting for RVALID; pointer is 2 before reset
      r_delay = 5;
      set_req(1, 0, 32'h4, 32'h0, 4'h0);
      grant(1);
      for (int c = 0; c < 20 && !axi.rready; c++) begin @(negedge clk); #1; end
      chk("rst_in_rd_data", axi.rready, 1'b1);
      b_p = n_pulse;
      set_req(0, 0, 32'h0, 32'h0, 4'h0);
      set_req(3, 0, 32'hC, 32'h0, 4'h0);
      #2 rst = 1'b1;
      #1;
      chk("rst_outs", {req_ready, rsp_valid, busy, rsp_rdata, rsp_resp, axi.awvalid, axi.wvalid,
                       axi.arvalid, axi.bready, axi.rready}, 64'h0);
      r_delay = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      grant(1);
      chk("rst_first_gnt", gl[gn-1], 0);
      chk("rst_no_pulse", n_pulse - b_p, 0);
      wait_rsp(1);
      pop_rsp("rst_r0", 0, 32'h0, 2'b00);
      grant(1);
      chk("rst_second_gnt", gl[gn-1], 3);
      wait_rsp(1);
      pop_rsp("rst_r3", 3, 32'h00BB00DD, 2'b00);
      chk("protocol_viol", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
